// File: rtl/hp_pkg.sv
`default_nettype none
// =============================================================================
// Module      : hp_pkg
// Description : Shared types and header-layout constants for header_parser.
// Revision    : 1.0 - initial release
// =============================================================================
package hp_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HDR     = 2'd1,
      PAYLOAD = 2'd2
   } hp_state_t;

   localparam int ETH_HDR_BYTES = 14;
   localparam int IP_HDR_BYTES  = 20;
   localparam int UDP_HDR_BYTES = 8;
   localparam int HDR_BYTES     = ETH_HDR_BYTES + IP_HDR_BYTES + UDP_HDR_BYTES;

   // First 8-byte data word lying wholly past the Ethernet/IP/UDP headers.
   localparam int DEF_PAYLOAD_WORD = (HDR_BYTES + 7) / 8;

   localparam logic [7:0] MOD_HDR_CTRL = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/header_parser.sv
`default_nettype none
// =============================================================================
// Module      : header_parser
// Description : One-cycle pass-through that tags each word with its data-word
//               index and a UDP-payload flag. Optional macro
//               HEADER_PARSER_PKT_COUNT_EN adds an EOP packet counter output.
// Revision    : 1.0 - initial release
// =============================================================================
module header_parser
   import hp_pkg::*;
#(
   parameter int DWIDTH       = 64,
   parameter int CTRL_WIDTH   = DWIDTH / 8,
   parameter int PAYLOAD_WORD = DEF_PAYLOAD_WORD
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic [DWIDTH-1:0]     in_data,
   input  logic [CTRL_WIDTH-1:0] in_ctrl,
   input  logic                  in_wr,
   output logic                  in_rdy,
   output logic [DWIDTH-1:0]     out_data,
   output logic [CTRL_WIDTH-1:0] out_ctrl,
   output logic                  out_wr,
   input  logic                  out_rdy,
`ifdef HEADER_PARSER_PKT_COUNT_EN
   output logic [31:0]           o_pkt_count,
`endif
   output logic [15:0]           data_count,
   output logic                  o_inside_payload
);

   localparam logic [15:0] c_PAYLOAD_WORD = 16'(PAYLOAD_WORD);

   hp_state_t   r_state;
   hp_state_t   w_next_state;
   logic [15:0] r_cnt;
   logic [15:0] w_next_cnt;
   logic [15:0] w_cnt_inc;
   logic [15:0] w_tag_cnt;
   logic        w_tag_pl;
   logic        w_ctrl_zero;

   assign in_rdy      = out_rdy;
   assign w_ctrl_zero = (in_ctrl == '0);
   assign w_cnt_inc   = r_cnt + 16'd1;

   // State register plus the forwarding pipeline; tags only move on written words.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state          <= IDLE;
         r_cnt            <= 16'd0;
         out_data         <= '0;
         out_ctrl         <= '0;
         out_wr           <= 1'b0;
         data_count       <= 16'd0;
         o_inside_payload <= 1'b0;
      end else begin
         out_data <= in_data;
         out_ctrl <= in_ctrl;
         out_wr   <= in_wr;
         if (in_wr) begin
            r_state          <= w_next_state;
            r_cnt            <= w_next_cnt;
            data_count       <= w_tag_cnt;
            o_inside_payload <= w_tag_pl;
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_ctrl_zero) begin
               w_next_cnt   = 16'd1;
               w_next_state = (16'd1 >= c_PAYLOAD_WORD) ? PAYLOAD : HDR;
            end
         end
         HDR: begin
            if (w_ctrl_zero) begin
               w_next_cnt = w_cnt_inc;
               if (w_cnt_inc == c_PAYLOAD_WORD) w_next_state = PAYLOAD;
            end else begin
               w_next_cnt   = 16'd0;
               w_next_state = IDLE;
            end
         end
         PAYLOAD: begin
            if (w_ctrl_zero) begin
               if (r_cnt != 16'hFFFF) w_next_cnt = w_cnt_inc;
            end else begin
               w_next_cnt   = 16'd0;
               w_next_state = IDLE;
            end
         end
         default: begin
            w_next_cnt   = 16'd0;
            w_next_state = IDLE;
         end
      endcase
   end

   always_comb begin
      w_tag_cnt = r_cnt;
      w_tag_pl  = 1'b0;
      case (r_state)
         IDLE: begin
            w_tag_cnt = 16'd0;
            w_tag_pl  = w_ctrl_zero && (PAYLOAD_WORD == 0);
         end
         HDR:     w_tag_pl = 1'b0;
         PAYLOAD: w_tag_pl = 1'b1;
         default: w_tag_cnt = 16'd0;
      endcase
   end

`ifdef HEADER_PARSER_PKT_COUNT_EN
   logic [31:0] r_pkt_count;

   // A nonzero ctrl outside IDLE is the EOP of a packet in progress.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset)
         r_pkt_count <= 32'd0;
      else if (in_wr && !w_ctrl_zero && (r_state != IDLE))
         r_pkt_count <= r_pkt_count + 32'd1;
   end

   assign o_pkt_count = r_pkt_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_header_parser.sv
`default_nettype none
// =============================================================================
// Module      : tb_header_parser
// Description : Directed self-checking bench for header_parser.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_header_parser;
   import hp_pkg::*;

   logic        i_clock = 1'b0;
   logic        i_reset = 1'b1;
   logic [63:0] in_data = '0;
   logic [7:0]  in_ctrl = '0;
   logic        in_wr   = 1'b0;
   logic        in_rdy;
   logic [63:0] out_data;
   logic [7:0]  out_ctrl;
   logic        out_wr;
   logic        out_rdy = 1'b1;
   logic [15:0] data_count;
   logic        o_inside_payload;
`ifdef HEADER_PARSER_PKT_COUNT_EN
   logic [31:0] o_pkt_count;
`endif

   int total = 0;
   int bad   = 0;

   header_parser dut (
      .i_clock          (i_clock),
      .i_reset          (i_reset),
      .in_data          (in_data),
      .in_ctrl          (in_ctrl),
      .in_wr            (in_wr),
      .in_rdy           (in_rdy),
      .out_data         (out_data),
      .out_ctrl         (out_ctrl),
      .out_wr           (out_wr),
      .out_rdy          (out_rdy),
`ifdef HEADER_PARSER_PKT_COUNT_EN
      .o_pkt_count      (o_pkt_count),
`endif
      .data_count       (data_count),
      .o_inside_payload (o_inside_payload)
   );

   always #5 i_clock = ~i_clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one word, then check the forwarded copy and its tags after the edge.
   task automatic send(input logic [63:0] d, input logic [7:0] c, input logic w,
                       input int ec, input logic ep, input string tag);
      in_data = d;
      in_ctrl = c;
      in_wr   = w;
      @(posedge i_clock);
      #1;
      chk({tag, ".data"}, out_data, d);
      chk({tag, ".ctrl"}, {56'd0, out_ctrl}, {56'd0, c});
      chk({tag, ".wr"},   {63'd0, out_wr}, {63'd0, w});
      chk({tag, ".cnt"},  {48'd0, data_count}, 64'(ec));
      chk({tag, ".pl"},   {63'd0, o_inside_payload}, {63'd0, ep});
   endtask

   task automatic reset_pulse();
      i_reset = 1'b1;
      #2;
      chk("rst.wr",  {63'd0, out_wr}, 64'd0);
      chk("rst.cnt", {48'd0, data_count}, 64'd0);
      chk("rst.pl",  {63'd0, o_inside_payload}, 64'd0);
      i_reset = 1'b0;
   endtask

   initial begin
      // Reset held with writes active: nothing may leak through.
      in_wr   = 1'b1;
      in_data = 64'hDEAD_BEEF_0123_4567;
      in_ctrl = 8'h00;
      repeat (10) @(posedge i_clock);
      #1;
      chk("reset.data", out_data, 64'd0);
      chk("reset.ctrl", {56'd0, out_ctrl}, 64'd0);
      chk("reset.wr",   {63'd0, out_wr}, 64'd0);
      chk("reset.cnt",  {48'd0, data_count}, 64'd0);
      chk("reset.pl",   {63'd0, o_inside_payload}, 64'd0);
`ifdef HEADER_PARSER_PKT_COUNT_EN
      chk("reset.pkt",  {32'd0, o_pkt_count}, 64'd0);
`endif
      i_reset = 1'b0;
      #1;
      chk("release.wr", {63'd0, out_wr}, 64'd0);

      // Full packet: header, 8 data words, EOP.
      send(64'hC0DE_0000_0000_0001, MOD_HDR_CTRL, 1'b1, 0, 1'b0, "p1.hdr");
      for (int i = 0; i < 8; i++)
         send(64'hA5A5_0000_0000_0000 | 64'(i), 8'h00, 1'b1, i, (i >= 6), "p1.dat");
      send(64'hA5A5_0000_0000_00EE, 8'h80, 1'b1, 8, 1'b1, "p1.eop");

      // Short packet never reaches payload.
      send(64'hC0DE_0000_0000_0002, MOD_HDR_CTRL, 1'b1, 0, 1'b0, "p2.hdr");
      for (int i = 0; i < 3; i++)
         send(64'hB0B0_0000_0000_0000 | 64'(i), 8'h00, 1'b1, i, 1'b0, "p2.dat");
      send(64'hB0B0_0000_0000_00EE, 8'h01, 1'b1, 3, 1'b0, "p2.eop");

      // Next packet restarts at 0, with an idle gap between words 4 and 5.
      send(64'hC0DE_0000_0000_0003, MOD_HDR_CTRL, 1'b1, 0, 1'b0, "p3.hdr");
      for (int i = 0; i < 5; i++)
         send(64'hC3C3_0000_0000_0000 | 64'(i), 8'h00, 1'b1, i, 1'b0, "p3.dat");
      for (int i = 0; i < 3; i++)
         send(64'h1111_2222_3333_4444, 8'h00, 1'b0, 4, 1'b0, "p3.gap");
      send(64'hC3C3_0000_0000_0005, 8'h00, 1'b1, 5, 1'b0, "p3.d5");
      send(64'hC3C3_0000_0000_0006, 8'h00, 1'b1, 6, 1'b1, "p3.d6");
      send(64'hC3C3_0000_0000_00EE, 8'h0F, 1'b1, 7, 1'b1, "p3.eop");

      // Back-pressure is a pure combinational pass-through.
      out_rdy = 1'b0;
      #1;
      chk("bp.low",  {63'd0, in_rdy}, 64'd0);
      out_rdy = 1'b1;
      #1;
      chk("bp.high", {63'd0, in_rdy}, 64'd1);

      // Two back-to-back 64-word packets starting from a clean counter.
      in_wr = 1'b0;
      reset_pulse();
      for (int p = 0; p < 2; p++) begin
         send(64'hC0DE_0000_0000_0100 | 64'(p), MOD_HDR_CTRL, 1'b1, 0, 1'b0, "bb.hdr");
         for (int i = 0; i < 62; i++)
            send({32'hBB00_0000 | 32'(p), 32'(i)}, 8'h00, 1'b1, i, (i >= 6), "bb.dat");
         send({32'hBBEE_0000 | 32'(p), 32'h0}, 8'hFF, 1'b1, 62, 1'b1, "bb.eop");
      end
`ifdef HEADER_PARSER_PKT_COUNT_EN
      chk("bb.pkt", {32'd0, o_pkt_count}, 64'd2);
`endif

      // Reset mid-payload: the next data word becomes word 0.
      send(64'hC0DE_0000_0000_0004, MOD_HDR_CTRL, 1'b1, 0, 1'b0, "mr.hdr");
      for (int i = 0; i < 8; i++)
         send(64'hD0D0_0000_0000_0000 | 64'(i), 8'h00, 1'b1, i, (i >= 6), "mr.dat");
      reset_pulse();
      send(64'hD1D1_0000_0000_0000, 8'h00, 1'b1, 0, 1'b0, "mr.w0");
      send(64'hD1D1_0000_0000_0001, 8'h00, 1'b1, 1, 1'b0, "mr.w1");
      send(64'hD1D1_0000_0000_00EE, 8'h03, 1'b1, 2, 1'b0, "mr.eop");
`ifdef HEADER_PARSER_PKT_COUNT_EN
      chk("mr.pkt", {32'd0, o_pkt_count}, 64'd1);
`endif

      in_wr = 1'b0;
      repeat (2) @(posedge i_clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/header_parser.md
Name: header_parser

Overview:
- Single-stage streaming parser for the 64-bit data + 8-bit ctrl packet bus.
- Sits between packet ingress and the hardware accelerator (encrypt/decrypt).
- Forwards every word unchanged with one cycle of latency.
- Tags each output word with its data-word index and a flag marking UDP payload, so the downstream accelerator can transform payload only.

Parameters:
- DWIDTH, 64: data bus width in bits.
- CTRL_WIDTH, DWIDTH/8: ctrl bus width; one bit per data byte.
- PAYLOAD_WORD, 6: first data-word index counted as payload. Word 0 is the first ctrl==0 word; 14+20+8 header bytes lie in words 0..5.

Ports:
- i_clock  in  1  rising-edge clock.
- i_reset  in  1  asynchronous, active-high reset.
- in_data  in  DWIDTH  input word.
- in_ctrl  in  CTRL_WIDTH  input ctrl; nonzero = module header word, or end-of-packet (EOP) byte mask.
- in_wr  in  1  input word valid.
- in_rdy  out  1  upstream may write.
- out_data  out  DWIDTH  registered copy of in_data.
- out_ctrl  out  CTRL_WIDTH  registered copy of in_ctrl.
- out_wr  out  1  registered copy of in_wr.
- out_rdy  in  1  downstream ready.
- data_count  out  16  data-word index of the current out word.
- o_inside_payload  out  1  current out word is payload.

Behaviour:
- Reset (async, i_reset=1):
  - out_data=0, out_ctrl=0, out_wr=0, data_count=0, o_inside_payload=0.
  - State=IDLE, internal word counter=0.
- in_rdy = out_rdy, combinational; no internal buffering.
- Pipeline:
  - Every cycle: out_data<=in_data, out_ctrl<=in_ctrl, out_wr<=in_wr.
  - data_count and o_inside_payload are registered in the same cycle and are aligned with out_*.
  - Latency is exactly 1 cycle.
- State only advances on cycles with in_wr=1. Otherwise state and counter hold, and the tags of the last word are held.
- Writing while in_rdy=0 is an upstream protocol violation. The word is still forwarded; no error detection is required.
- States:
  - IDLE:
    - in_ctrl!=0: module header word. Tag count=0, payload=0, stay IDLE.
    - in_ctrl==0: first data word. Tag count=0, payload=(0>=PAYLOAD_WORD). Counter<=1, go to HDR.
  - HDR (counter<PAYLOAD_WORD):
    - Tag count=counter, payload=0.
    - ctrl==0: counter+1. Go to PAYLOAD when counter+1==PAYLOAD_WORD.
    - ctrl!=0: EOP; go to IDLE, counter<=0.
  - PAYLOAD:
    - Tag count=counter, payload=1.
    - ctrl==0: counter+1, saturating at 16'hFFFF.
    - ctrl!=0: EOP word, still tagged payload=1. Go to IDLE, counter<=0.
- Back-to-back packets: a module header word in the cycle right after an EOP is handled in IDLE with no bubble.
- Reset mid-packet: state returns to IDLE; the next ctrl==0 word is treated as data word 0.
- Short packet that ends before PAYLOAD_WORD: no payload is ever tagged.

Optional Feature:
- Macro HEADER_PARSER_PKT_COUNT_EN.
- Defined:
  - Adds output o_pkt_count[31:0], reset to 0.
  - Increments once per accepted EOP word; wraps at 2^32.
  - Updated in the same cycle as the EOP's out_wr.
- Undefined: port absent; no counter logic.

Decomposition:
- Shared package hp_pkg holds:
  - state enum {IDLE, HDR, PAYLOAD};
  - localparams ETH_HDR_BYTES=14, IP_HDR_BYTES=20, UDP_HDR_BYTES=8;
  - the module header ctrl value 8'hFF.
- No sub-module is needed; a single flat module with the FSM and counter.

Test Plan:
- Reset: assert i_reset for 10 cycles with in_wr=1 → all outputs 0; after release, out_wr follows in_wr one cycle later.
- One packet: ctrl=FF header, then 8 words ctrl=0, then EOP ctrl=0x80.
  - Each output word equals the input word, delayed 1 cycle.
  - data_count sequence: 0,0,1,2,3,4,5,6,7,8.
  - o_inside_payload is 1 only on data words 6,7 and on the EOP word (count 8).
- Short packet: header + 3 data words + EOP (ctrl=0x01) → payload never 1; the following packet restarts at count 0.
- Gaps: insert 3 idle cycles (in_wr=0) between data words 4 and 5 → out_wr=0 during the gap; count resumes at 5 with no skip.
- Back-pressure: drive out_rdy=0 → in_rdy=0 in the same cycle; out_rdy=1 → in_rdy=1.
- Back-to-back packets and mid-packet reset:
  - Two 64-word packets with no gap → the second packet's data word 0 is tagged count 0.
  - Reset pulse during payload → the next data word is tagged count 0, payload=0.
  - With HEADER_PARSER_PKT_COUNT_EN defined, o_pkt_count=2 after both packets.
